// File: rtl/inv_result_checker.sv
// Response checker for the inverter bench path: each accepted (stim, resp) pair is checked against ~stim.
// Latency: every result updates on the accepting edge and is visible on the following cycle.
// Backpressure: in_ready is high only in ACTIVE. Pairs offered in any other state are ignored.
//
// Ports:
//   clk, reset_n            rising-edge clock, asynchronous active-low reset
//   start                   one-cycle pulse: clears all results and enters ACTIVE (from any state)
//   in_valid/in_ready       handshake for the stim/resp pair
//   stim, resp              value driven into the DUT / value observed on its output
//   pass_cnt, fail_cnt      saturating match / mismatch counters
//   fail_seen               sticky mismatch flag
//   first_fail_stim/resp    the first mismatching pair since start
//   coverage, cov_done      per-code exercised map; all codes seen (DONE state)
//   busy                    checker is in ACTIVE
// Optional build macro INV_CHK_HALT_ON_FAIL_EN: the first mismatch stops acceptance (HALT state)
// until the next start.
module inv_result_checker #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        stim,
    input  logic [WIDTH-1:0]        resp,
    output logic [CNT_W-1:0]        pass_cnt,
    output logic [CNT_W-1:0]        fail_cnt,
    output logic                    fail_seen,
    output logic [WIDTH-1:0]        first_fail_stim,
    output logic [WIDTH-1:0]        first_fail_resp,
    output logic [(1<<WIDTH)-1:0]   coverage,
    output logic                    cov_done,
    output logic                    busy
);

    localparam int NCODES = 1 << WIDTH;

`ifdef INV_CHK_HALT_ON_FAIL_EN
    typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, DONE = 2'd2, HALT = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, DONE = 2'd2} state_t;
`endif

    state_t state;
    state_t state_next;

    logic              accept;
    logic              match;
    logic [NCODES-1:0] stim_bit;
    logic              cov_full;

    // start takes priority over a same-cycle handshake: that pair is dropped.
    assign accept = in_valid && in_ready && !start;
    assign match  = (resp == ~stim);

    always_comb begin
        stim_bit       = '0;
        stim_bit[stim] = 1'b1;
    end

    // True when this accept fills the last missing coverage bit.
    assign cov_full = &(coverage | stim_bit);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        if (start) begin
            state_next = ACTIVE;
        end else if (state == ACTIVE && accept) begin
            if (cov_full) begin
                state_next = DONE;
            end
`ifdef INV_CHK_HALT_ON_FAIL_EN
            // A mismatch halts even if it also completed the sweep.
            if (!match) begin
                state_next = HALT;
            end
`endif
        end
    end

    // Output logic, decoded from the registered state
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        cov_done = 1'b0;
        case (state)
            ACTIVE: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            DONE: begin
                cov_done = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    // Result datapath
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pass_cnt        <= '0;
            fail_cnt        <= '0;
            fail_seen       <= 1'b0;
            first_fail_stim <= '0;
            first_fail_resp <= '0;
            coverage        <= '0;
        end else if (start) begin
            pass_cnt        <= '0;
            fail_cnt        <= '0;
            fail_seen       <= 1'b0;
            first_fail_stim <= '0;
            first_fail_resp <= '0;
            coverage        <= '0;
        end else if (accept) begin
            coverage <= coverage | stim_bit;
            if (match) begin
                if (pass_cnt != {CNT_W{1'b1}}) begin
                    pass_cnt <= pass_cnt + 1'b1;
                end
            end else begin
                if (fail_cnt != {CNT_W{1'b1}}) begin
                    fail_cnt <= fail_cnt + 1'b1;
                end
                fail_seen <= 1'b1;
                if (!fail_seen) begin
                    first_fail_stim <= stim;
                    first_fail_resp <= resp;
                end
            end
        end
    end

endmodule

// File: tb/tb_inv_result_checker.sv
// Scoreboard bench for inv_result_checker: a reference model predicts the result state after each
// driven cycle, the prediction is queued, and it is popped and compared one cycle later.
module tb_inv_result_checker;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        in_valid;
    logic [3:0]  stim;
    logic [3:0]  resp;

    logic        in_ready;
    logic [7:0]  pass_cnt;
    logic [7:0]  fail_cnt;
    logic        fail_seen;
    logic [3:0]  first_fail_stim;
    logic [3:0]  first_fail_resp;
    logic [15:0] coverage;
    logic        cov_done;
    logic        busy;

    // Second instance with 2-bit counters, driven by the same stimulus, for saturation.
    logic        s_in_ready;
    logic [1:0]  s_pass_cnt;
    logic [1:0]  s_fail_cnt;
    logic        s_fail_seen;
    logic [3:0]  s_first_fail_stim;
    logic [3:0]  s_first_fail_resp;
    logic [15:0] s_coverage;
    logic        s_cov_done;
    logic        s_busy;

    inv_result_checker #(.WIDTH(4), .CNT_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .stim(stim), .resp(resp), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .fail_seen(fail_seen),
        .first_fail_stim(first_fail_stim), .first_fail_resp(first_fail_resp),
        .coverage(coverage), .cov_done(cov_done), .busy(busy)
    );

    inv_result_checker #(.WIDTH(4), .CNT_W(2)) dut_sat (
        .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid), .in_ready(s_in_ready),
        .stim(stim), .resp(resp), .pass_cnt(s_pass_cnt), .fail_cnt(s_fail_cnt),
        .fail_seen(s_fail_seen), .first_fail_stim(s_first_fail_stim),
        .first_fail_resp(s_first_fail_resp), .coverage(s_coverage), .cov_done(s_cov_done),
        .busy(s_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, want);
        end
    endtask

    // Reference model: 0=IDLE 1=ACTIVE 2=DONE 3=HALT
    typedef struct packed {
        logic [7:0]  pass;
        logic [7:0]  fail;
        logic        fs;
        logic [3:0]  ffs;
        logic [3:0]  ffr;
        logic [15:0] cov;
        logic        rdy;
        logic        bsy;
        logic        done;
        logic [1:0]  pass2;
    } exp_t;

    exp_t exp_q[$];

    int          m_state;
    int          m_pass;
    int          m_fail;
    int          m_pass2;
    logic        m_fs;
    logic [3:0]  m_ffs;
    logic [3:0]  m_ffr;
    logic [15:0] m_cov;

    task automatic model_clear();
        m_pass = 0; m_fail = 0; m_pass2 = 0;
        m_fs = 1'b0; m_ffs = 4'h0; m_ffr = 4'h0; m_cov = 16'h0;
    endtask

    function automatic exp_t snap();
        exp_t e;
        e.pass  = m_pass[7:0];
        e.fail  = m_fail[7:0];
        e.fs    = m_fs;
        e.ffs   = m_ffs;
        e.ffr   = m_ffr;
        e.cov   = m_cov;
        e.rdy   = (m_state == 1);
        e.bsy   = (m_state == 1);
        e.done  = (m_state == 2);
        e.pass2 = m_pass2[1:0];
        return e;
    endfunction

    task automatic compare(input string tag, input exp_t e);
        check_eq({tag, ".pass_cnt"},  pass_cnt,        e.pass);
        check_eq({tag, ".fail_cnt"},  fail_cnt,        e.fail);
        check_eq({tag, ".fail_seen"}, fail_seen,       e.fs);
        check_eq({tag, ".ff_stim"},   first_fail_stim, e.ffs);
        check_eq({tag, ".ff_resp"},   first_fail_resp, e.ffr);
        check_eq({tag, ".coverage"},  coverage,        e.cov);
        check_eq({tag, ".in_ready"},  in_ready,        e.rdy);
        check_eq({tag, ".busy"},      busy,            e.bsy);
        check_eq({tag, ".cov_done"},  cov_done,        e.done);
        check_eq({tag, ".pass2"},     s_pass_cnt,      e.pass2);
    endtask

    // One clock: drive at a falling edge, predict the rising-edge effect, compare at the next fall.
    task automatic step(input string tag, input bit st, input bit v,
                        input logic [3:0] s, input logic [3:0] r);
        start = st; in_valid = v; stim = s; resp = r;
        if (st) begin
            model_clear();
            m_state = 1;
        end else if (v && m_state == 1) begin
            if (r == ~s) begin
                if (m_pass < 255) m_pass++;
                if (m_pass2 < 3) m_pass2++;
            end else begin
                if (m_fail < 255) m_fail++;
                if (!m_fs) begin
                    m_ffs = s;
                    m_ffr = r;
                end
                m_fs = 1'b1;
            end
            m_cov[s] = 1'b1;
            if (m_cov == 16'hFFFF) m_state = 2;
`ifdef INV_CHK_HALT_ON_FAIL_EN
            if (r != ~s) m_state = 3;
`endif
        end
        exp_q.push_back(snap());
        @(negedge clk);
        compare(tag, exp_q.pop_front());
        start = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        logic [3:0] code;
        reset_n = 1'b0; start = 1'b0; in_valid = 1'b0; stim = 4'h0; resp = 4'h0;
        m_state = 0;
        model_clear();
        repeat (2) @(negedge clk);
        compare("por", snap());
        reset_n = 1'b1;

        // Pairs offered before any start are ignored.
        step("idle_ign", 1'b0, 1'b1, 4'h1, 4'hE);

        // Reset in the middle of a sweep with pass_cnt=3.
        step("rst_start", 1'b1, 1'b0, 4'h0, 4'h0);
        for (int i = 0; i < 3; i++) begin
            code = 4'(i);
            step("rst_pre", 1'b0, 1'b1, code, ~code);
        end
        check_eq("rst_pre_pass3", pass_cnt, 32'd3);
        #2 reset_n = 1'b0;
        m_state = 0;
        model_clear();
        #1 compare("async_rst", snap());
        @(negedge clk);
        reset_n = 1'b1;
        step("rst_ign", 1'b0, 1'b1, 4'h2, 4'hD);

        // Full correct sweep, back-to-back.
        step("full_start", 1'b1, 1'b0, 4'h0, 4'h0);
        for (int i = 0; i < 16; i++) begin
            code = 4'(i);
            step("full", 1'b0, 1'b1, code, ~code);
        end
        check_eq("full_pass16", pass_cnt, 32'd16);
        check_eq("full_cov", coverage, 32'hFFFF);
        check_eq("full_done", cov_done, 32'd1);
        check_eq("full_rdy0", in_ready, 32'd0);
        step("done_ign", 1'b0, 1'b1, 4'h0, 4'h0);

        // Sweep skipping code 6.
        step("skip_start", 1'b1, 1'b0, 4'h0, 4'h0);
        for (int i = 0; i < 16; i++) begin
            code = 4'(i);
            if (i != 6) step("skip", 1'b0, 1'b1, code, ~code);
        end
        check_eq("skip_cov", coverage, 32'hFFBF);
        check_eq("skip_done0", cov_done, 32'd0);
        check_eq("skip_rdy1", in_ready, 32'd1);

        // Injected failures.
        step("fail_start", 1'b1, 1'b0, 4'h0, 4'h0);
        step("fail1", 1'b0, 1'b1, 4'h3, 4'b0011);
        step("fail2", 1'b0, 1'b1, 4'h5, 4'b0000);
        check_eq("fail_ffs", first_fail_stim, 32'd3);
        check_eq("fail_ffr", first_fail_resp, 32'b0011);
`ifdef INV_CHK_HALT_ON_FAIL_EN
        check_eq("halt_fail1", fail_cnt, 32'd1);
        check_eq("halt_rdy0", in_ready, 32'd0);
        check_eq("halt_cov", coverage, 32'h0008);
`else
        check_eq("fail_cnt2", fail_cnt, 32'd2);
        check_eq("fail_cov", coverage, 32'h0028);
`endif

        // start colliding with a handshake mid-sweep.
        step("coll_start", 1'b1, 1'b0, 4'h0, 4'h0);
        for (int i = 0; i < 7; i++) begin
            code = 4'(i);
            step("coll_pre", 1'b0, 1'b1, code, ~code);
        end
        step("coll", 1'b1, 1'b1, 4'h7, 4'h8);
        check_eq("coll_pass0", pass_cnt, 32'd0);
        check_eq("coll_cov0", coverage, 32'd0);
        check_eq("coll_busy", busy, 32'd1);

        // Saturation on the 2-bit-counter instance.
        step("sat_start", 1'b1, 1'b0, 4'h0, 4'h0);
        for (int i = 0; i < 6; i++) step("sat", 1'b0, 1'b1, 4'h0, 4'hF);
        check_eq("sat_pass3", s_pass_cnt, 32'd3);
        check_eq("sat_cov", s_coverage, 32'h0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inv_result_checker.md
Name: inv_result_checker

Overview:
Self-checking response end for the 4-bit inverter bench path. It accepts (stimulus, observed response) pairs over a valid/ready handshake and checks each response against the bitwise inverse of its stimulus. It keeps pass/fail counts, captures the first failing pair, and tracks which input codes have been exercised. It lets a bench (or an on-chip BIST sequencer) prove an exhaustive, correct sweep without relying on a human reading printed output.

Parameters:
WIDTH, 4, data width of stimulus/response; coverage map is 2^WIDTH bits
CNT_W, 8, width of pass/fail counters (saturating)

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous, active-low reset
start  input  1  single-cycle pulse; clears results and arms the checker
in_valid  input  1  stim/resp pair is presented
in_ready  output  1  checker can accept a pair this cycle
stim  input  WIDTH  value driven into the DUT
resp  input  WIDTH  value observed on the DUT output
pass_cnt  output  CNT_W  number of matching pairs
fail_cnt  output  CNT_W  number of mismatching pairs
fail_seen  output  1  sticky; at least one mismatch since start
first_fail_stim  output  WIDTH  stim of the first mismatch
first_fail_resp  output  WIDTH  resp of the first mismatch
coverage  output  2^WIDTH  bit k set once stim==k has been accepted
cov_done  output  1  all 2^WIDTH codes accepted
busy  output  1  checker is in ACTIVE

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE; all counters, captures, coverage, fail_seen and cov_done=0; in_ready=0; busy=0.
- States:
  - IDLE: in_ready=0; start -> ACTIVE.
  - ACTIVE: in_ready=1, busy=1; remains here until full coverage.
  - DONE: in_ready=0, cov_done=1; start -> ACTIVE.
- Start action: on the edge where start=1, the checker clears the counters, captures, coverage and fail_seen, and enters ACTIVE. This applies from any state, including mid-sweep. If start and a handshake occur in the same cycle, start wins and the pair is dropped.
- Accept: a pair is accepted when in_valid & in_ready at a rising edge.
  - Expected value = ~stim (WIDTH bits). Match means resp == expected.
- Latency: results update on the accepting edge and are visible the following cycle (registered outputs, one-cycle latency).
- On a match: pass_cnt increments.
- On a mismatch: fail_cnt increments and fail_seen is set. If fail_seen was 0 before this edge, first_fail_stim/resp capture the pair. Later failures do not overwrite the capture.
- Every accepted pair sets coverage[stim], including failing pairs. Repeated codes are counted again; coverage is unchanged.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- Completion: on the edge where the accepted stim sets the last zero coverage bit, state goes to DONE. cov_done and in_ready=0 are visible the next cycle.
- in_valid while in_ready=0: ignored; no state change.
- Outputs hold their values in IDLE and DONE until the next start or reset.

Optional Feature:
Macro INV_CHK_HALT_ON_FAIL_EN.
- Defined: adds state HALT. The first mismatch moves the checker ACTIVE -> HALT on the same edge that captures the pair. In HALT, in_ready=0, busy=0 and cov_done=0; only start or reset leaves HALT.
- Not defined: there is no HALT state, and mismatches never stop acceptance.

Test Plan:
- Reset during ACTIVE with pass_cnt=3: after reset_n low, all outputs are 0 and state is IDLE; in_valid is ignored until start.
- start, then 16 pairs stim=0..15 with resp=~stim back-to-back: pass_cnt=16, fail_cnt=0, coverage=16'hFFFF. cov_done=1 and in_ready=0 one cycle after the 16th accept.
- Sweep skipping stim=4'b0110 (15 codes, all correct): pass_cnt=15, coverage=16'hFFBF, cov_done=0, in_ready stays 1.
- Inject failures stim=3/resp=4'b0011, then stim=5/resp=4'b0000:
  - Without the macro: fail_cnt=2, first_fail_stim=3, first_fail_resp=4'b0011, coverage bits 3 and 5 set.
  - With INV_CHK_HALT_ON_FAIL_EN: HALT after the first failure, fail_cnt=1, in_ready=0, and the second pair is not accepted.
- start asserted in the same cycle as a handshake mid-sweep (pass_cnt=7): next cycle pass_cnt=0, coverage=0, busy=1, and the dropped pair is not counted.
- CNT_W=2, six matching pairs of stim=0: pass_cnt saturates at 3, coverage=16'h0001.
